// File: rtl/i2c_pkg.sv
// Shared types for the I2C bit engine: the command encoding and the FSM state set.
package i2c_pkg;

  typedef enum logic [2:0] {
    START_CMD   = 3'd0,
    WR_CMD      = 3'd1,
    RD_CMD      = 3'd2,
    STOP_CMD    = 3'd3,
    RESTART_CMD = 3'd4
  } i2c_cmd_t;

  typedef enum logic [3:0] {
    StIdle, StHold, StStart1, StStart2, StRs1, StRs2,
    StData1, StData2, StData3, StData4, StStop1, StStop2, StStop3
  } i2c_state_e;

endpackage

// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: generates START/RESTART/STOP conditions and 9-bit byte transfers,
// with every SCL phase lasting a programmable number of clock cycles.
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int unsigned DVSR_WIDTH = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  i2c_cmd_t              cmd,
  input  logic                  cmd_valid,
  input  logic [DATA_BITS-1:0]  din,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  en_ack,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  ack,
  output logic [DATA_BITS-1:0]  dout,
  output logic                  bus_busy
);

  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS);
  localparam logic [BitW-1:0] BitOne = BitW'(1);
  localparam logic [DVSR_WIDTH-1:0] QOne = DVSR_WIDTH'(1);

  i2c_state_e             r_state;
  logic [DVSR_WIDTH-1:0]  r_cnt, r_q;
  logic [BitW-1:0]        r_bit;
  logic [DATA_BITS-1:0]   r_shift, r_dout;
  logic                   r_is_rd, r_en_ack, r_ack_smp, r_ack;
  logic                   r_scl, r_sda, r_done, r_busy;

  logic                   w_accept, w_phase_end;
  logic [DVSR_WIDTH-1:0]  w_q;
  logic [BitW-1:0]        w_bit_nxt;

  // Bit index LastBit is the ACK slot; the rest carry data.
  function automatic logic tx_bit(input logic is_rd, input logic ea,
                                  input logic [BitW-1:0] idx, input logic msb);
    if (idx == LastBit) return is_rd ? ~ea : 1'b1;
    return is_rd ? 1'b1 : msb;
  endfunction

  assign ready       = (r_state == StIdle) || (r_state == StHold);
  assign w_accept    = cmd_valid & ready;
  assign w_q         = (dvsr == '0) ? QOne : dvsr;
  assign w_phase_end = (r_cnt == r_q - QOne);
  assign w_bit_nxt   = r_bit + BitOne;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_q       <= QOne;
      r_bit     <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_is_rd   <= 1'b0;
      r_en_ack  <= 1'b0;
      r_ack_smp <= 1'b0;
      r_ack     <= 1'b0;
      r_scl     <= 1'b1;
      r_sda     <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept && cmd == START_CMD) begin
            r_q     <= w_q;
            r_cnt   <= '0;
            r_state <= StStart1;
            r_scl   <= 1'b1;
            r_sda   <= 1'b0;
          end
        end
        StHold: begin
          if (w_accept) begin
            r_q      <= w_q;
            r_cnt    <= '0;
            r_en_ack <= en_ack;
            r_is_rd  <= (cmd == RD_CMD);
            case (cmd)
              START_CMD, RESTART_CMD: begin
                r_state <= StRs1;
                r_scl   <= 1'b0;
                r_sda   <= 1'b1;
              end
              WR_CMD, RD_CMD: begin
                r_state <= StData1;
                r_bit   <= '0;
                r_shift <= din;
                r_scl   <= 1'b0;
                r_sda   <= tx_bit(cmd == RD_CMD, en_ack, '0, din[DATA_BITS-1]);
              end
              STOP_CMD: begin
                r_state <= StStop1;
                r_scl   <= 1'b0;
                r_sda   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: begin
          if (!w_phase_end) begin
            r_cnt <= r_cnt + QOne;
          end else begin
            r_cnt <= '0;
            case (r_state)
              StStart1: begin
                r_state <= StStart2;
                r_scl   <= 1'b0;
                r_sda   <= 1'b0;
              end
              StStart2: begin
                r_state <= StHold;
                r_done  <= 1'b1;
                r_busy  <= 1'b1;
              end
              StRs1: begin
                r_state <= StRs2;
                r_scl   <= 1'b1;
              end
              StRs2: begin
                r_state <= StStart1;
                r_sda   <= 1'b0;
              end
              StData1: begin
                r_state <= StData2;
                r_scl   <= 1'b1;
              end
              StData2: begin
                // Sample in the middle of SCL high; shifting also exposes the next TX bit.
                r_state <= StData3;
                if (r_bit == LastBit) r_ack_smp <= ~sda_i;
                else r_shift <= {r_shift[DATA_BITS-2:0], sda_i};
              end
              StData3: begin
                r_state <= StData4;
                r_scl   <= 1'b0;
              end
              StData4: begin
                if (r_bit == LastBit) begin
                  r_state <= StHold;
                  r_sda   <= 1'b0;
                  r_done  <= 1'b1;
                  if (r_is_rd) r_dout <= r_shift;
                  else r_ack <= r_ack_smp;
                end else begin
                  r_state <= StData1;
                  r_bit   <= w_bit_nxt;
                  r_sda   <= tx_bit(r_is_rd, r_en_ack, w_bit_nxt, r_shift[DATA_BITS-1]);
                end
              end
              StStop1: begin
                r_state <= StStop2;
                r_scl   <= 1'b1;
              end
              StStop2: begin
                r_state <= StStop3;
                r_sda   <= 1'b1;
              end
              StStop3: begin
                r_state <= StIdle;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
              default: r_state <= StIdle;
            endcase
          end
        end
      endcase
    end
  end

  assign scl_o     = r_scl;
  assign sda_o     = r_sda;
  assign done_tick = r_done;
  assign ack       = r_ack;
  assign dout      = r_dout;
  assign bus_busy  = r_busy;

endmodule

// File: doc/i2c_bit_engine.md
I2C_BIT_ENGINE -- requirements
Module: i2c_bit_engine

Interface
REQ-001 Parameter: DVSR_WIDTH, default 16, width of the quarter-period divisor.
REQ-002 Parameter: DATA_BITS, default 8, bits per byte transfer.
REQ-003 Port: clk  in  1  single system clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: cmd  in  3  command, type i2c_cmd_t.
REQ-006 Port: cmd_valid  in  1  command request; accepted when cmd_valid & ready.
REQ-007 Port: din  in  DATA_BITS  byte to transmit on WR_CMD.
REQ-008 Port: dvsr  in  DVSR_WIDTH  clk cycles per quarter SCL period (q).
REQ-009 Port: en_ack  in  1  on RD_CMD, 1 = master drives ACK, 0 = NACK.
REQ-010 Port: sda_i  in  1  sampled SDA line.
REQ-011 Port: scl_o  out  1  SCL drive; 1 = release (high-Z), 0 = pull low.
REQ-012 Port: sda_o  out  1  SDA drive; 1 = release, 0 = pull low.
REQ-013 Port: ready  out  1  engine can accept a command.
REQ-014 Port: done_tick  out  1  one-cycle pulse when a command completes.
REQ-015 Port: ack  out  1  slave ACK of last WR_CMD (1 = SDA sampled low on bit 9).
REQ-016 Port: dout  out  DATA_BITS  byte received by last RD_CMD.
REQ-017 Port: bus_busy  out  1  high from START completion until STOP completion.

Function
REQ-018 Commands SHALL be START_CMD, WR_CMD, RD_CMD, STOP_CMD, RESTART_CMD.
REQ-019 cmd, din, dvsr, en_ack SHALL be latched at acceptance; later input changes SHALL not affect the running command.
REQ-020 Latched q SHALL be max(dvsr,1); each phase lasts exactly q cycles.
REQ-021 States: IDLE, HOLD, START1, START2, RS1, RS2, DATA1, DATA2, DATA3, DATA4, STOP1, STOP2, STOP3.
REQ-022 ready SHALL be high only in IDLE and HOLD.
REQ-023 IDLE: scl_o=1, sda_o=1; HOLD: scl_o=0, sda_o=0.
REQ-024 START_CMD in IDLE: START1 (scl 1, sda 0) -> START2 (scl 0, sda 0) -> HOLD; 2q cycles.
REQ-025 START_CMD or RESTART_CMD in HOLD: RS1 (scl 0, sda 1) -> RS2 (scl 1, sda 1) -> START1 -> START2 -> HOLD; 4q cycles.
REQ-026 WR_CMD/RD_CMD in HOLD: 9 bits, each DATA1 (scl 0, sda set) -> DATA2 (scl 1) -> DATA3 (scl 1) -> DATA4 (scl 0); 36q cycles, then HOLD.
REQ-027 WR: bits 1-8 drive din MSB first; bit 9 sda_o=1; ack = ~sda_i sampled on last cycle of DATA2.
REQ-028 RD: bits 1-8 sda_o=1, sda_i shifted in MSB first on last cycle of DATA2; bit 9 sda_o = ~en_ack_latched.
REQ-029 STOP_CMD in HOLD: STOP1 (scl 0, sda 0) -> STOP2 (scl 1, sda 0) -> STOP3 (scl 1, sda 1) -> IDLE; 3q cycles.
REQ-030 WR/RD/STOP/RESTART accepted in IDLE SHALL be ignored: no state change, no done_tick.
REQ-031 done_tick SHALL pulse in the first cycle the FSM is back in HOLD or IDLE after a legal command.
REQ-032 dout and ack SHALL update only on RD/WR completion and hold otherwise.
REQ-033 A sampled sda_i mismatch (arbitration) SHALL NOT be detected; out of scope.

Reset
REQ-034 On rst: state IDLE, scl_o=1, sda_o=1, ready=1, done_tick=0, ack=0, dout=0, bus_busy=0, counters 0; takes effect next posedge even mid-command.

Structure
REQ-035 i2c_cmd_t (3-bit enum: START_CMD=0, WR_CMD=1, RD_CMD=2, STOP_CMD=3, RESTART_CMD=4) SHALL reside in i2c_pkg.
REQ-036 Single module, no sub-modules; phase counter, bit counter (0-8), shift register inline.

Verification
REQ-037 dvsr=4, START in IDLE -> sda_o falls while scl_o=1, done_tick 8 cycles after acceptance, bus_busy=1.
REQ-038 dvsr=4, WR din=0xA5, sda_i=0 on bit 9 -> sda_o bits 1,0,1,0,0,1,0,1, ack=1, done_tick 144 cycles later.
REQ-039 dvsr=2, RD, sda_i driven 0x3C, en_ack=0 -> dout=0x3C, sda_o=1 during bit 9, done_tick after 72 cycles.
REQ-040 dvsr=0 vs 1, STOP from HOLD -> both complete in 3 cycles, sda_o rises while scl_o=1, bus_busy=0, IDLE.
REQ-041 rst asserted mid-WR -> next cycle scl_o=1, sda_o=1, ready=1, no done_tick.
REQ-042 WR_CMD in IDLE -> ready stays 1, no done_tick, scl_o/sda_o stay 1.
